spi_flash_op_sequencer: RTL and testbench

Sequences multi-command flash operations (read, page program, sector erase) on top of the SPI flash wrapper's single-command interface. Accepts one high-level operation at a time, issues the command chain (WREN → program/erase → RDSR polling until WIP clears), and steers the wrapper's RX stream either to the user (read data) or internally (status polling). It sits between the bus-side register/DMA logic and `spi_flash_wrapper`.

---
 rtl/spi_flash_op_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_spi_flash_op_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_op_sequencer.sv
// Runs a multi-command flash operation (read / page program / sector erase)
// over the single-command spi_flash_wrapper. It issues WREN, the main command
// and RDSR polling, and steers wrapper RX data to the user or to the poller.
// Ports: op_* request handshake; done/err/busy status; cmd_o..prescaler_o with
//        start/clr_status drive the wrapper; status_i is the wrapper EOT;
//        wr_rx_* is the wrapper RX FIFO; usr_rx_* is the user read-data stream.
module spi_flash_op_sequencer #(
  parameter logic [5:0]  PRESCALER  = 6'd2,
  parameter logic [15:0] POLL_LIMIT = 16'hFFFF,
  parameter logic [7:0]  POLL_GAP   = 8'd16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        op_valid_i,
  output logic        op_ready_o,
  input  logic [1:0]  op_type_i,
  input  logic [23:0] op_addr_i,
  input  logic [7:0]  op_len_i,
  input  logic        op_quad_i,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o,
  output logic [7:0]  cmd_o,
  output logic [1:0]  data_mode_o,
  output logic        rd_wr_o,
  output logic [4:0]  dummy_o,
  output logic [7:0]  data_count_o,
  output logic        has_addr_o,
  output logic [23:0] addr_o,
  output logic [5:0]  prescaler_o,
  output logic        start_o,
  output logic        clr_status_o,
  input  logic        status_i,
  input  logic [31:0] wr_rx_data_i,
  input  logic        wr_rx_valid_i,
  output logic        wr_rx_ready_o,
  output logic [31:0] usr_rx_data_o,
  output logic        usr_rx_valid_o,
  input  logic        usr_rx_ready_i
);

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_PROG = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_ISSUE_WREN, S_WAIT_WREN, S_ISSUE_MAIN, S_WAIT_MAIN,
    S_ISSUE_POLL, S_WAIT_POLL, S_POLL_RX, S_POLL_GAP, S_DONE
  } state_t;

  state_t      state, state_d;
  logic        live;          // low until the first clock after reset release
  logic [1:0]  type_q;
  logic [23:0] addr_q;
  logic [7:0]  len_q;
  logic        quad_q;
  logic        err_q;
  logic [15:0] poll_cnt;
  logic [7:0]  gap_cnt;
  logic        accept;
  logic        wip;
  logic        gap_last;

  // Main-command fields; in IDLE they come straight from the request so the
  // ISSUE_MAIN cycle right after accept already carries the right command.
  logic [1:0]  m_type;
  logic [23:0] m_addr;
  logic [7:0]  m_len;
  logic        m_quad;
  logic [7:0]  m_cmd;
  logic [1:0]  m_mode;
  logic        m_rd;
  logic [4:0]  m_dummy;
  logic [7:0]  m_count;

  assign accept   = op_ready_o & op_valid_i;
  assign wip      = wr_rx_data_i[0];
  assign gap_last = ({1'b0, gap_cnt} + 9'd1) >= {1'b0, POLL_GAP};

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op_type_i)
            OP_READ:           state_d = S_ISSUE_MAIN;
            OP_PROG, OP_ERASE: state_d = S_ISSUE_WREN;
            default:           state_d = S_DONE;
          endcase
        end
      end
      S_ISSUE_WREN: state_d = S_WAIT_WREN;
      S_WAIT_WREN:  if (status_i) state_d = S_ISSUE_MAIN;
      S_ISSUE_MAIN: state_d = S_WAIT_MAIN;
      S_WAIT_MAIN:  if (status_i) state_d = (type_q == OP_READ) ? S_DONE : S_ISSUE_POLL;
      S_ISSUE_POLL: state_d = S_WAIT_POLL;
      S_WAIT_POLL:  if (status_i) state_d = S_POLL_RX;
      S_POLL_RX: begin
        if (wr_rx_valid_i) begin
          if (!wip || poll_cnt == POLL_LIMIT) state_d = S_DONE;
          else                                state_d = S_POLL_GAP;
        end
      end
      S_POLL_GAP:   if (gap_last) state_d = S_ISSUE_POLL;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    op_ready_o     = live && (state == S_IDLE);
    busy_o         = (state != S_IDLE);
    start_o        = (state == S_ISSUE_WREN) || (state == S_ISSUE_MAIN) || (state == S_ISSUE_POLL);
    clr_status_o   = start_o;
    done_o         = (state == S_DONE);
    err_o          = (state == S_DONE) && err_q;
    usr_rx_data_o  = wr_rx_data_i;
    usr_rx_valid_o = live && (state != S_POLL_RX) && wr_rx_valid_i;
    wr_rx_ready_o  = live && ((state == S_POLL_RX) || usr_rx_ready_i);
  end

  // Operation context, poll and gap counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      live     <= 1'b0;
      type_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      quad_q   <= 1'b0;
      err_q    <= 1'b0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        type_q   <= op_type_i;
        addr_q   <= op_addr_i;
        len_q    <= op_len_i;
        quad_q   <= op_quad_i;
        err_q    <= (op_type_i == 2'b11);
        poll_cnt <= '0;
      end else if (state == S_POLL_RX && wr_rx_valid_i && wip) begin
        // Compare before increment so the counter never wraps.
        if (poll_cnt == POLL_LIMIT) err_q    <= 1'b1;
        else                        poll_cnt <= poll_cnt + 16'd1;
      end
      gap_cnt <= (state == S_POLL_GAP) ? gap_cnt + 8'd1 : 8'd0;
    end
  end

  always_comb begin
    m_type  = (state == S_IDLE) ? op_type_i : type_q;
    m_addr  = (state == S_IDLE) ? op_addr_i : addr_q;
    m_len   = (state == S_IDLE) ? op_len_i  : len_q;
    m_quad  = (state == S_IDLE) ? op_quad_i : quad_q;
    m_cmd   = 8'h20;
    m_mode  = 2'b00;
    m_rd    = 1'b0;
    m_dummy = 5'd0;
    m_count = 8'd0;
    case (m_type)
      OP_READ: begin
        m_cmd   = m_quad ? 8'h6B : 8'h03;
        m_mode  = m_quad ? 2'b11 : 2'b01;
        m_rd    = 1'b1;
        m_dummy = m_quad ? 5'd8 : 5'd0;
        m_count = m_len;
      end
      OP_PROG: begin
        m_cmd   = m_quad ? 8'h32 : 8'h02;
        m_mode  = m_quad ? 2'b11 : 2'b01;
        m_count = m_len;
      end
      default: ;
    endcase
  end

  // Command fields load only on entry to an ISSUE state and then hold
  // through the wrapper transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_o        <= '0;
      data_mode_o  <= '0;
      rd_wr_o      <= 1'b0;
      dummy_o      <= '0;
      data_count_o <= '0;
      has_addr_o   <= 1'b0;
      addr_o       <= '0;
      prescaler_o  <= '0;
    end else if (state_d != state) begin
      case (state_d)
        S_ISSUE_WREN: begin
          cmd_o <= 8'h06; data_mode_o <= 2'b00; rd_wr_o <= 1'b0; dummy_o <= 5'd0;
          data_count_o <= 8'd0; has_addr_o <= 1'b0; addr_o <= 24'd0; prescaler_o <= PRESCALER;
        end
        S_ISSUE_MAIN: begin
          cmd_o <= m_cmd; data_mode_o <= m_mode; rd_wr_o <= m_rd; dummy_o <= m_dummy;
          data_count_o <= m_count; has_addr_o <= 1'b1; addr_o <= m_addr; prescaler_o <= PRESCALER;
        end
        S_ISSUE_POLL: begin
          cmd_o <= 8'h05; data_mode_o <= 2'b01; rd_wr_o <= 1'b1; dummy_o <= 5'd0;
          data_count_o <= 8'd0; has_addr_o <= 1'b0; addr_o <= 24'd0; prescaler_o <= PRESCALER;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_op_sequencer.sv
`timescale 1ns/1ps
module tb_spi_flash_op_sequencer;
  localparam logic [15:0] LIMIT = 16'd4;
  localparam logic [7:0]  GAP   = 8'd16;
  localparam int          LAT   = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic op_valid_i = 1'b0, op_ready_o, op_quad_i = 1'b0;
  logic [1:0] op_type_i = '0;
  logic [23:0] op_addr_i = '0;
  logic [7:0] op_len_i = '0;
  logic done_o, err_o, busy_o, rd_wr_o, has_addr_o, start_o, clr_status_o;
  logic [7:0] cmd_o, data_count_o;
  logic [1:0] data_mode_o;
  logic [4:0] dummy_o;
  logic [23:0] addr_o;
  logic [5:0] prescaler_o;
  logic status_i = 1'b0;
  logic [31:0] wr_rx_data_i = '0, usr_rx_data_o;
  logic wr_rx_valid_i = 1'b0, wr_rx_ready_o, usr_rx_valid_o;
  logic usr_rx_ready_i = 1'b1;

  always #5 clk = ~clk;

  spi_flash_op_sequencer #(.PRESCALER(6'd2), .POLL_LIMIT(LIMIT), .POLL_GAP(GAP)) dut (
    .clk(clk), .rstn(rstn),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_type_i(op_type_i),
    .op_addr_i(op_addr_i), .op_len_i(op_len_i), .op_quad_i(op_quad_i),
    .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
    .cmd_o(cmd_o), .data_mode_o(data_mode_o), .rd_wr_o(rd_wr_o), .dummy_o(dummy_o),
    .data_count_o(data_count_o), .has_addr_o(has_addr_o), .addr_o(addr_o),
    .prescaler_o(prescaler_o), .start_o(start_o), .clr_status_o(clr_status_o),
    .status_i(status_i), .wr_rx_data_i(wr_rx_data_i), .wr_rx_valid_i(wr_rx_valid_i),
    .wr_rx_ready_o(wr_rx_ready_o), .usr_rx_data_o(usr_rx_data_o),
    .usr_rx_valid_o(usr_rx_valid_o), .usr_rx_ready_i(usr_rx_ready_i)
  );

  typedef struct packed {
    logic [7:0]  cmd;
    logic [1:0]  mode;
    logic        rd_wr;
    logic [4:0]  dummy;
    logic [7:0]  count;
    logic        has_addr;
    logic [23:0] addr;
  } cmd_t;

  cmd_t        exp_cmd_q[$];
  logic [31:0] exp_usr_q[$];
  logic [31:0] rx_q[$];
  int          start_cycs[$];
  int tests = 0, fails = 0;
  int cyc = 0;
  int rdsr_cnt = 0, usr_cnt = 0, last_rdsr = -1, eot_cyc = -1;
  int wip_ones = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic cmd_t mk(input logic [7:0] c, input logic [1:0] m, input logic rw,
                              input logic [4:0] d, input logic [7:0] n, input logic h,
                              input logic [23:0] a);
    mk = {c, m, rw, d, n, h, a};
  endfunction

  function automatic cmd_t rdsr_cmd();
    rdsr_cmd = mk(8'h05, 2'b01, 1'b1, 5'd0, 8'd0, 1'b0, 24'd0);
  endfunction

  // Wrapper + flash model with the command and user-data scoreboards.
  initial begin : wrapper_model
    cmd_t seen, e;
    logic fire, st, clr, pend, wbit;
    logic [7:0] cur_cmd, cur_count;
    logic [15:0] data_ctr;
    logic [31:0] w;
    int lat, nw;
    pend = 1'b0; lat = 0; data_ctr = 16'h1000; cur_cmd = '0; cur_count = '0;
    forever begin
      @(negedge clk);
      fire = wr_rx_valid_i && wr_rx_ready_o;
      st   = start_o;
      clr  = clr_status_o;
      seen = {cmd_o, data_mode_o, rd_wr_o, dummy_o, data_count_o, has_addr_o, addr_o};
      if (usr_rx_valid_o && usr_rx_ready_i) begin
        tests++;
        if (exp_usr_q.size() == 0) begin
          fails++; $display("FAIL usr_unexpected got=%h want=none", usr_rx_data_o);
        end else begin
          w = exp_usr_q.pop_front();
          usr_cnt++;
          if (usr_rx_data_o !== w) begin
            fails++; $display("FAIL usr_data got=%h want=%h", usr_rx_data_o, w);
          end
        end
      end
      if (st) begin
        start_cycs.push_back(cyc);
        tests++;
        if (exp_cmd_q.size() == 0) begin
          fails++; $display("FAIL cmd_unexpected got=%h want=none", seen);
        end else begin
          e = exp_cmd_q.pop_front();
          if (seen !== e || prescaler_o !== 6'd2) begin
            fails++; $display("FAIL cmd_fields got=%h/%0d want=%h/2", seen, prescaler_o, e);
          end
        end
        if (cmd_o == 8'h05) begin
          rdsr_cnt++;
          if (last_rdsr >= 0) begin
            tests++;
            if (cyc - last_rdsr <= int'(GAP)) begin
              fails++; $display("FAIL poll_gap got=%0d want>%0d", cyc - last_rdsr, GAP);
            end
          end
          last_rdsr = cyc;
        end
      end
      @(posedge clk); #1;
      if (!rstn) begin
        rx_q.delete(); status_i = 1'b0; lat = 0; pend = 1'b0;
      end else begin
        if (fire && rx_q.size() > 0) void'(rx_q.pop_front());
        if (pend) begin
          wbit = (wip_ones > 0);
          rx_q.push_back({31'h0, wbit});
          if (wip_ones > 0) wip_ones--;
          pend = 1'b0;
        end
        if (clr) status_i = 1'b0;
        if (st) begin
          lat = LAT; cur_cmd = seen.cmd; cur_count = seen.count;
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            status_i = 1'b1;
            eot_cyc = cyc;
            if (cur_cmd == 8'h05) pend = 1'b1;
            else if (cur_cmd == 8'h03 || cur_cmd == 8'h6B) begin
              nw = (int'(cur_count) + 4) / 4;
              for (int i = 0; i < nw; i++) begin
                w = {cur_cmd, data_ctr, 8'(i)};
                rx_q.push_back(w);
                exp_usr_q.push_back(w);
              end
              data_ctr++;
            end
          end
        end
      end
      wr_rx_valid_i = (rx_q.size() > 0);
      wr_rx_data_i  = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
    end
  end

  task automatic drive_op(input logic [1:0] t, input logic [23:0] a, input logic [7:0] l,
                          input logic q, output int acc);
    int n;
    n = 0; acc = -1;
    @(posedge clk); #1;
    op_valid_i = 1'b1; op_type_i = t; op_addr_i = a; op_len_i = l; op_quad_i = q;
    while (acc < 0 && n < 50) begin
      @(negedge clk);
      if (op_ready_o) acc = cyc;
      n++;
      @(posedge clk); #1;
    end
    op_valid_i = 1'b0;
    tests++;
    if (acc < 0) begin fails++; $display("FAIL accept_timeout got=no_ready want=ready"); end
  endtask

  task automatic wait_done(output int dcyc, output logic derr);
    int n;
    n = 0; dcyc = -1; derr = 1'b0;
    while (dcyc < 0 && n < 3000) begin
      @(negedge clk);
      if (done_o) begin dcyc = cyc; derr = err_o; end
      n++;
    end
    tests++;
    if (dcyc < 0) begin fails++; $display("FAIL done_timeout got=no_done want=done"); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({op_ready_o, done_o, err_o, busy_o, start_o, clr_status_o, usr_rx_valid_o, wr_rx_ready_o} !== 8'h0) begin
      fails++; $display("FAIL reset_ctrl got=%b want=00000000",
        {op_ready_o, done_o, err_o, busy_o, start_o, clr_status_o, usr_rx_valid_o, wr_rx_ready_o});
    end
    tests++;
    if ({cmd_o, data_mode_o, rd_wr_o, dummy_o, data_count_o, has_addr_o, addr_o, prescaler_o} !== 55'h0) begin
      fails++; $display("FAIL reset_fields got=%h want=0", {cmd_o, data_mode_o, rd_wr_o, dummy_o, data_count_o, has_addr_o, addr_o, prescaler_o});
    end
    @(posedge clk); #1; rstn = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (op_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      fails++; $display("FAIL idle_ready got=%b%b want=10", op_ready_o, busy_o);
    end
  endtask

  task automatic check_read(input string nm, input logic [23:0] a, input logic [7:0] l,
                            input logic q, input int nw);
    int acc, dcyc, s0, u0;
    logic derr;
    exp_cmd_q.push_back(mk(q ? 8'h6B : 8'h03, q ? 2'b11 : 2'b01, 1'b1, q ? 5'd8 : 5'd0, l, 1'b1, a));
    s0 = start_cycs.size(); u0 = usr_cnt;
    drive_op(2'b00, a, l, q, acc);
    wait_done(dcyc, derr);
    tests++;
    if (start_cycs.size() != s0 + 1) begin
      fails++; $display("FAIL %s_starts got=%0d want=1", nm, start_cycs.size() - s0);
    end else begin
      tests++;
      if (start_cycs[s0] != acc + 1) begin
        fails++; $display("FAIL %s_start_lat got=%0d want=%0d", nm, start_cycs[s0], acc + 1);
      end
    end
    tests++;
    if (dcyc != eot_cyc + 1) begin fails++; $display("FAIL %s_done_lat got=%0d want=%0d", nm, dcyc, eot_cyc + 1); end
    tests++;
    if (derr !== 1'b0) begin fails++; $display("FAIL %s_err got=%b want=0", nm, derr); end
    repeat (8) @(negedge clk);
    tests++;
    if (usr_cnt - u0 != nw || exp_usr_q.size() != 0) begin
      fails++; $display("FAIL %s_usr_words got=%0d want=%0d", nm, usr_cnt - u0, nw);
    end
    tests++;
    if (exp_cmd_q.size() != 0) begin fails++; $display("FAIL %s_cmds_left got=%0d want=0", nm, exp_cmd_q.size()); end
  endtask

  task automatic check_write(input string nm, input logic [1:0] t, input logic [23:0] a,
                             input logic [7:0] l, input logic q, input int wips,
                             input int polls, input logic want_err);
    int acc, dcyc, s0, u0, r0;
    logic derr;
    wip_ones = wips; last_rdsr = -1;
    s0 = start_cycs.size(); u0 = usr_cnt; r0 = rdsr_cnt;
    exp_cmd_q.push_back(mk(8'h06, 2'b00, 1'b0, 5'd0, 8'd0, 1'b0, 24'd0));
    if (t == 2'b01) exp_cmd_q.push_back(mk(q ? 8'h32 : 8'h02, q ? 2'b11 : 2'b01, 1'b0, 5'd0, l, 1'b1, a));
    else            exp_cmd_q.push_back(mk(8'h20, 2'b00, 1'b0, 5'd0, 8'd0, 1'b1, a));
    for (int i = 0; i < polls; i++) exp_cmd_q.push_back(rdsr_cmd());
    drive_op(t, a, l, q, acc);
    wait_done(dcyc, derr);
    tests++;
    if (start_cycs.size() <= s0 || start_cycs[s0] != acc + 1) begin
      fails++; $display("FAIL %s_wren_lat got=%0d starts want=%0d", nm, start_cycs.size() - s0, acc + 1);
    end
    tests++;
    if (rdsr_cnt - r0 != polls) begin fails++; $display("FAIL %s_polls got=%0d want=%0d", nm, rdsr_cnt - r0, polls); end
    tests++;
    if (derr !== want_err) begin fails++; $display("FAIL %s_err got=%b want=%b", nm, derr, want_err); end
    repeat (4) @(negedge clk);
    tests++;
    if (usr_cnt != u0) begin fails++; $display("FAIL %s_usr_leak got=%0d want=0", nm, usr_cnt - u0); end
    tests++;
    if (exp_cmd_q.size() != 0) begin fails++; $display("FAIL %s_cmds_left got=%0d want=0", nm, exp_cmd_q.size()); end
    wip_ones = 0;
  endtask

  task automatic test_reserved();
    int acc, dcyc, s0;
    logic derr;
    s0 = start_cycs.size();
    drive_op(2'b11, 24'h123456, 8'd5, 1'b0, acc);
    wait_done(dcyc, derr);
    tests++;
    if (dcyc != acc + 1) begin fails++; $display("FAIL rsvd_done_lat got=%0d want=%0d", dcyc, acc + 1); end
    tests++;
    if (derr !== 1'b1) begin fails++; $display("FAIL rsvd_err got=%b want=1", derr); end
    repeat (4) @(negedge clk);
    tests++;
    if (start_cycs.size() != s0) begin fails++; $display("FAIL rsvd_start got=%0d want=0", start_cycs.size() - s0); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, d1, d2;
    logic e1, e2;
    exp_cmd_q.push_back(mk(8'h03, 2'b01, 1'b1, 5'd0, 8'd3, 1'b1, 24'h000040));
    exp_cmd_q.push_back(mk(8'h6B, 2'b11, 1'b1, 5'd8, 8'd11, 1'b1, 24'h000080));
    drive_op(2'b00, 24'h000040, 8'd3, 1'b0, acc1);
    op_valid_i = 1'b1; op_type_i = 2'b11;   // must be ignored while busy
    wait_done(d1, e1);
    op_valid_i = 1'b0;
    drive_op(2'b00, 24'h000080, 8'd11, 1'b1, acc2);
    wait_done(d2, e2);
    tests++;
    if (e1 !== 1'b0 || e2 !== 1'b0) begin fails++; $display("FAIL b2b_err got=%b%b want=00", e1, e2); end
    tests++;
    if (acc2 != d1 + 1) begin fails++; $display("FAIL b2b_accept got=%0d want=%0d", acc2, d1 + 1); end
    repeat (8) @(negedge clk);
    tests++;
    if (exp_cmd_q.size() != 0 || exp_usr_q.size() != 0) begin
      fails++; $display("FAIL b2b_left got=%0d/%0d want=0/0", exp_cmd_q.size(), exp_usr_q.size());
    end
  endtask

  task automatic test_reset_mid_op();
    int acc, n, r0;
    wip_ones = 1000; last_rdsr = -1; r0 = rdsr_cnt;
    exp_cmd_q.push_back(mk(8'h06, 2'b00, 1'b0, 5'd0, 8'd0, 1'b0, 24'd0));
    exp_cmd_q.push_back(mk(8'h20, 2'b00, 1'b0, 5'd0, 8'd0, 1'b1, 24'h00A000));
    exp_cmd_q.push_back(rdsr_cmd());
    drive_op(2'b10, 24'h00A000, 8'd0, 1'b0, acc);
    n = 0;
    while (rdsr_cnt == r0 && n < 500) begin @(negedge clk); n++; end
    tests++;
    if (rdsr_cnt == r0) begin fails++; $display("FAIL midrst_poll got=no_rdsr want=rdsr"); end
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    tests++;
    if ({op_ready_o, done_o, err_o, busy_o, start_o, clr_status_o, usr_rx_valid_o, wr_rx_ready_o} !== 8'h0) begin
      fails++; $display("FAIL midrst_ctrl got=%b want=00000000",
        {op_ready_o, done_o, err_o, busy_o, start_o, clr_status_o, usr_rx_valid_o, wr_rx_ready_o});
    end
    tests++;
    if ({cmd_o, data_mode_o, rd_wr_o, dummy_o, data_count_o, has_addr_o, addr_o, prescaler_o} !== 55'h0) begin
      fails++; $display("FAIL midrst_fields got=%h want=0", {cmd_o, data_mode_o, rd_wr_o, dummy_o, data_count_o, has_addr_o, addr_o, prescaler_o});
    end
    @(posedge clk); #1;
    exp_cmd_q.delete(); exp_usr_q.delete(); wip_ones = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (op_ready_o !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b want=1", op_ready_o); end
    check_read("post_reset_read", 24'h002040, 8'd3, 1'b0, 1);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    check_read("std_read", 24'h001000, 8'd7, 1'b0, 2);
    check_read("quad_read", 24'h3FF000, 8'd3, 1'b1, 1);
    check_write("page_program", 2'b01, 24'h000100, 8'd15, 1'b0, 3, 4, 1'b0);
    check_write("quad_program", 2'b01, 24'h000200, 8'd31, 1'b1, 0, 1, 1'b0);
    check_write("erase_timeout", 2'b10, 24'h005000, 8'd0, 1'b0, 1000, 5, 1'b1);
    test_reserved();
    test_back_to_back();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
